// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the tiny16 ALU arbiter.
// Arbitration mode is selected by ALU_ARB_RR_EN (see alu_arb_grant).
package alu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_FLAG = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam int DATA_W = 16;
    localparam int OPC_W  = 4;
    localparam int FLG_W  = 4;

    localparam logic [OPC_W-1:0] OP_ADD = 4'd3;
    localparam logic [OPC_W-1:0] OP_SUB = 4'd4;
    localparam logic [OPC_W-1:0] OP_MUL = 4'd5;
    localparam logic [OPC_W-1:0] OP_DIV = 4'd6;
    localparam logic [OPC_W-1:0] OP_AND = 4'd7;
    localparam logic [OPC_W-1:0] OP_OR  = 4'd8;
    localparam logic [OPC_W-1:0] OP_XOR = 4'd9;
    localparam logic [OPC_W-1:0] OP_SHL = 4'd10;
    localparam logic [OPC_W-1:0] OP_SHR = 4'd11;

    localparam int FLG_O = 3;
    localparam int FLG_C = 2;
    localparam int FLG_N = 1;
    localparam int FLG_Z = 0;

    localparam logic [DATA_W-1:0] DIV_ZERO_RESULT = 16'hFFFF;

    // A divide with a zero divisor is answered locally and never reaches the ALU.
    function automatic logic is_div_zero(input logic [OPC_W-1:0]  opcode,
                                         input logic [DATA_W-1:0] src2);
        return (opcode == OP_DIV) && (src2 == '0);
    endfunction

endpackage

// File: rtl/alu_arb_grant.sv
// Grant selection between the two ALU requesters.
// ALU_ARB_RR_EN defined: round-robin on ties; undefined: requester 0 has fixed priority.
module alu_arb_grant
    import alu_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       idle,
    input  logic       accept,
    output logic [1:0] grant
);

`ifdef ALU_ARB_RR_EN
    // ptr names the requester that wins the next simultaneous request
    logic ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= ~grant[1];
        end
    end

    always_comb begin
        grant = 2'b00;
        if (idle) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clk, rst, accept};

    always_comb begin
        grant = 2'b00;
        if (idle) begin
            if (valid[0]) begin
                grant = 2'b01;
            end else if (valid[1]) begin
                grant = 2'b10;
            end
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one tiny16 ALU between two requesters; results return tagged with the requester ID.
// Define ALU_ARB_RR_EN for round-robin arbitration, otherwise requester 0 has fixed priority.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OPC_W-1:0]  req0_opcode,
    input  logic              req0_ar_flag,
    input  logic [DATA_W-1:0] req0_src1,
    input  logic [DATA_W-1:0] req0_src2,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OPC_W-1:0]  req1_opcode,
    input  logic              req1_ar_flag,
    input  logic [DATA_W-1:0] req1_src1,
    input  logic [DATA_W-1:0] req1_src2,

    output logic [OPC_W-1:0]  alu_opcode,
    output logic              alu_ar_flag,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    output logic              alu_out_en,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [FLG_W-1:0]  alu_flags,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic [FLG_W-1:0]  rsp_flags,
    output logic              rsp_err
);

    state_t            state;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   grant;
    logic              idle;
    logic              accept;

    logic              sel_id;
    logic [OPC_W-1:0]  sel_opcode;
    logic              sel_ar_flag;
    logic [DATA_W-1:0] sel_src1;
    logic [DATA_W-1:0] sel_src2;

    assign req_valid = {req1_valid, req0_valid};

    // Ready is forced low while reset is asserted so nothing is accepted in that cycle.
    assign idle   = (state == ST_IDLE) && !rst;
    assign accept = |(req_valid & grant);

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    alu_arb_grant u_grant (
        .clk    (clk),
        .rst    (rst),
        .valid  (req_valid),
        .idle   (idle),
        .accept (accept),
        .grant  (grant)
    );

    always_comb begin
        sel_id      = grant[1];
        sel_opcode  = sel_id ? req1_opcode  : req0_opcode;
        sel_ar_flag = sel_id ? req1_ar_flag : req0_ar_flag;
        sel_src1    = sel_id ? req1_src1    : req0_src1;
        sel_src2    = sel_id ? req1_src2    : req0_src2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            alu_opcode  <= '0;
            alu_ar_flag <= 1'b0;
            alu_src1    <= '0;
            alu_src2    <= '0;
            alu_out_en  <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_result  <= '0;
            rsp_flags   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        alu_opcode  <= sel_opcode;
                        alu_ar_flag <= sel_ar_flag;
                        alu_src1    <= sel_src1;
                        alu_src2    <= sel_src2;
                        rsp_id      <= sel_id;
                        if (is_div_zero(sel_opcode, sel_src2)) begin
                            rsp_result <= DIV_ZERO_RESULT;
                            rsp_flags  <= '0;
                            rsp_err    <= 1'b1;
                            rsp_valid  <= 1'b1;
                            state      <= ST_RESP;
                        end else begin
                            alu_out_en <= 1'b1;
                            state      <= ST_EXEC;
                        end
                    end
                end
                // ALU result is combinational; its flags register on this same edge.
                ST_EXEC: begin
                    rsp_result <= alu_out;
                    alu_out_en <= 1'b0;
                    state      <= ST_FLAG;
                end
                ST_FLAG: begin
                    rsp_flags  <= {alu_flags[FLG_O], alu_flags[FLG_C],
                                   alu_flags[FLG_N], alu_flags[FLG_Z]};
                    rsp_err    <= 1'b0;
                    rsp_valid  <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural tiny16 ALU attached.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_opcode = '0, req1_opcode = '0;
    logic        req0_ar_flag = 1'b0, req1_ar_flag = 1'b0;
    logic [15:0] req0_src1 = '0, req0_src2 = '0, req1_src1 = '0, req1_src2 = '0;

    logic [3:0]  alu_opcode;
    logic        alu_ar_flag;
    logic [15:0] alu_src1, alu_src2;
    logic        alu_out_en;
    logic [15:0] alu_out;
    logic [3:0]  alu_flags;

    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_id;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_ar_flag(req0_ar_flag), .req0_src1(req0_src1), .req0_src2(req0_src2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_ar_flag(req1_ar_flag), .req1_src1(req1_src1), .req1_src2(req1_src2),
        .alu_opcode(alu_opcode), .alu_ar_flag(alu_ar_flag), .alu_src1(alu_src1),
        .alu_src2(alu_src2), .alu_out_en(alu_out_en), .alu_out(alu_out), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    // Behavioural tiny16 ALU: {O,C,N,Z,result}
    function automatic logic [19:0] alu_model(input logic [3:0] op, input logic ar,
                                              input logic [15:0] a, input logic [15:0] b);
        logic [16:0] w;
        logic [31:0] p;
        logic [15:0] r;
        logic        o, c;
        w = '0; p = '0; r = '0; o = 1'b0; c = 1'b0;
        case (op)
            4'd3: begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16];
                        o = (a[15] == b[15]) && (r[15] != a[15]); end
            4'd4: begin w = {1'b0, a} - {1'b0, b}; r = w[15:0]; c = w[16];
                        o = (a[15] != b[15]) && (r[15] != a[15]); end
            4'd5: begin p = a * b; r = p[15:0]; c = |p[31:16]; o = c; end
            4'd6: r = (b == 16'd0) ? 16'hFFFF : a / b;
            4'd7: r = a & b;
            4'd8: r = a | b;
            4'd9: r = a ^ b;
            4'd10: r = a << b[3:0];
            4'd11: r = ar ? 16'($signed(a) >>> b[3:0]) : (a >> b[3:0]);
            default: r = '0;
        endcase
        return {o, c, r[15], (r == 16'd0), r};
    endfunction

    logic [19:0] alu_calc;
    logic [3:0]  alu_flags_q = 4'b0000;
    assign alu_calc  = alu_model(alu_opcode, alu_ar_flag, alu_src1, alu_src2);
    assign alu_out   = alu_calc[15:0];
    assign alu_flags = alu_flags_q;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (alu_out_en) begin
            alu_flags_q <= alu_calc[19:16];
            en_cnt      <= en_cnt + 1;
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents a request and returns one step after the accepting edge (EXEC cycle).
    task automatic issue(input int id, input logic [3:0] op, input logic ar,
                         input logic [15:0] s1, input logic [15:0] s2);
        bit got;
        if (id == 0) begin
            req0_opcode = op; req0_ar_flag = ar; req0_src1 = s1; req0_src2 = s2; req0_valid = 1'b1;
        end else begin
            req1_opcode = op; req1_ar_flag = ar; req1_src1 = s1; req1_src2 = s2; req1_valid = 1'b1;
        end
        #1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
                got = 1'b1;
                break;
            end
            step(1);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL issue_ready: requester %0d not granted within 20 cycles (ready=0, required 1)", id);
        end
        @(posedge clk);
        #1;
        if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1;
        step(2);
        checks++;
        if (req0_ready !== 1'b0) begin errors++;
            $display("FAIL reset_ready: got %b required 0", req0_ready); end
        checks++;
        if (rsp_valid !== 1'b0 || alu_out_en !== 1'b0) begin errors++;
            $display("FAIL reset_valid_en: rsp_valid=%b alu_out_en=%b required 0/0", rsp_valid, alu_out_en); end
        checks++;
        if (alu_opcode !== 4'd0 || alu_src1 !== 16'd0 || rsp_result !== 16'd0 || rsp_flags !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs: opcode=%h src1=%h result=%h flags=%b required all 0",
                     alu_opcode, alu_src1, rsp_result, rsp_flags);
        end
        req0_valid = 1'b0;
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_add();
        rsp_ready = 1'b0;
        issue(0, 4'd3, 1'b0, 16'h7FFF, 16'h0001);
        checks++;
        if (alu_out_en !== 1'b1 || alu_opcode !== 4'd3 || alu_src1 !== 16'h7FFF || alu_src2 !== 16'h0001) begin
            errors++;
            $display("FAIL add_exec_drive: en=%b op=%h s1=%h s2=%h required 1/3/7fff/0001",
                     alu_out_en, alu_opcode, alu_src1, alu_src2);
        end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++;
            $display("FAIL add_early_valid_exec: got %b required 0", rsp_valid); end
        step(1);
        checks++;
        if (rsp_valid !== 1'b0 || alu_out_en !== 1'b0) begin errors++;
            $display("FAIL add_flag_cycle: rsp_valid=%b alu_out_en=%b required 0/0", rsp_valid, alu_out_en); end
        step(1);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 16'h8000 ||
            rsp_flags !== 4'b1010 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL add_response: valid=%b id=%b result=%h flags=%b err=%b required 1/0/8000/1010/0",
                     rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err);
        end
        rsp_ready = 1'b1;
        step(1);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || alu_opcode !== 4'd3) begin errors++;
            $display("FAIL add_accept: rsp_valid=%b alu_opcode=%h required 0/3", rsp_valid, alu_opcode); end
    endtask

    task automatic test_div_zero();
        int en_before;
        en_before = en_cnt;
        rsp_ready = 1'b0;
        issue(1, 4'd6, 1'b0, 16'd100, 16'd0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_result !== 16'hFFFF ||
            rsp_flags !== 4'b0000 || rsp_id !== 1'b1) begin
            errors++;
            $display("FAIL div0_response: valid=%b err=%b result=%h flags=%b id=%b required 1/1/ffff/0000/1",
                     rsp_valid, rsp_err, rsp_result, rsp_flags, rsp_id);
        end
        rsp_ready = 1'b1;
        step(1);
        rsp_ready = 1'b0;
        step(2);
        checks++;
        if (en_cnt !== en_before) begin errors++;
            $display("FAIL div0_out_en: alu_out_en cycles %0d required 0", en_cnt - en_before); end
        checks++;
        if (alu_flags !== 4'b1010) begin errors++;
            $display("FAIL div0_alu_flags: got %b required 1010", alu_flags); end
    endtask

    task automatic test_simultaneous();
        int exp_grant [4];
        int last_cyc;
`ifdef ALU_ARB_RR_EN
        exp_grant = '{0, 1, 0, 1};
`else
        exp_grant = '{0, 0, 0, 0};
`endif
        last_cyc = 0;
        rsp_ready = 1'b1;
        req0_opcode = 4'd3; req0_src1 = 16'd1; req0_src2 = 16'd1;
        req1_opcode = 4'd7; req1_src1 = 16'hFF00; req1_src2 = 16'h0FF0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (req0_ready || req1_ready) begin got = 1'b1; break; end
                step(1);
            end
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL simul_timeout: grant %0d not seen", g);
            end else begin
                if (req0_ready && req1_ready) begin
                    errors++;
                    $display("FAIL simul_both_ready: got 11 required one-hot");
                end else if ((req1_ready ? 1 : 0) != exp_grant[g]) begin
                    errors++;
                    $display("FAIL simul_grant%0d: got %0d required %0d", g, req1_ready ? 1 : 0, exp_grant[g]);
                end
                if (g > 0) begin
                    checks++;
                    if (cyc - last_cyc != 4) begin errors++;
                        $display("FAIL simul_spacing: got %0d cycles required 4", cyc - last_cyc); end
                end
                last_cyc = cyc;
            end
            step(1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step(4);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++;
            $display("FAIL simul_drain: rsp_valid=%b required 0", rsp_valid); end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        issue(0, 4'd3, 1'b0, 16'd2, 16'd2);
        step(2);
        req0_opcode = 4'd8; req0_src1 = 16'h00F0; req0_src2 = 16'h0F00;
        req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== 16'd4 || rsp_flags !== 4'b0000 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b result=%h flags=%b ready=%b%b required 1/0004/0000/00",
                         i, rsp_valid, rsp_result, rsp_flags, req1_ready, req0_ready);
            end
            step(1);
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0) begin errors++;
            $display("FAIL bp_ready_during_accept: got %b required 0", req0_ready); end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin errors++;
            $display("FAIL bp_ready_after_accept: got %b required 1", req0_ready); end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        step(2);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 16'h0FF0 || rsp_flags !== 4'b0000 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL bp_second: valid=%b result=%h flags=%b id=%b required 1/0ff0/0000/0",
                     rsp_valid, rsp_result, rsp_flags, rsp_id);
        end
        rsp_ready = 1'b1;
        step(1);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_in_flag();
        rsp_ready = 1'b0;
        issue(0, 4'd4, 1'b0, 16'd5, 16'd5);
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || alu_out_en !== 1'b0 || alu_opcode !== 4'd0 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstflag_state: valid=%b en=%b op=%h ready=%b required 0/0/0/0",
                     rsp_valid, alu_out_en, alu_opcode, req0_ready);
        end
        step(3);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++;
            $display("FAIL rstflag_discard: rsp_valid=%b required 0", rsp_valid); end
        issue(0, 4'd3, 1'b0, 16'd2, 16'd3);
        step(2);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 16'd5 || rsp_flags !== 4'b0000 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL rstflag_add: valid=%b result=%h flags=%b err=%b required 1/0005/0000/0",
                     rsp_valid, rsp_result, rsp_flags, rsp_err);
        end
        rsp_ready = 1'b1;
        step(1);
        rsp_ready = 1'b0;
    endtask

    task automatic test_zero_flag();
        rsp_ready = 1'b0;
        issue(0, 4'd9, 1'b0, 16'hA5A5, 16'hA5A5);
        step(2);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 16'h0000 || rsp_flags !== 4'b0001) begin
            errors++;
            $display("FAIL zero_flag: valid=%b result=%h flags=%b required 1/0000/0001",
                     rsp_valid, rsp_result, rsp_flags);
        end
        rsp_ready = 1'b1;
        step(1);
        rsp_ready = 1'b0;
    endtask

    task automatic test_unsupported();
        rsp_ready = 1'b0;
        issue(1, 4'd13, 1'b0, 16'h1234, 16'h0000);
        step(2);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 16'h0000 || rsp_flags !== 4'b0001 ||
            rsp_err !== 1'b0 || rsp_id !== 1'b1) begin
            errors++;
            $display("FAIL unsupported_op: valid=%b result=%h flags=%b err=%b id=%b required 1/0000/0001/0/1",
                     rsp_valid, rsp_result, rsp_flags, rsp_err, rsp_id);
        end
        rsp_ready = 1'b1;
        step(1);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_div_zero();
        test_simultaneous();
        test_backpressure();
        test_reset_in_flag();
        test_zero_flag();
        test_unsupported();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
